// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: FSM state enum, instruction size, IF/ID payload struct.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Purpose: one-entry holding register for an instruction that arrived while decode was stalled.
// Latency: entry visible the cycle after load; unload frees it at the next edge.
// Backpressure: none itself; the owner only loads when the entry is free.
// Ports: load/load_dat write the entry, unload frees it, clear (priority) drops it,
//        entry_dat/valid show the held payload.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   unload,
  input  logic   clear,
  input  if_id_t load_dat,
  output if_id_t entry_dat,
  output logic   valid
);

  logic   valid_q, valid_d;
  if_id_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      entry_d = load_dat;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid     = valid_q;
  assign entry_dat = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch between the PC register and IF/ID; single outstanding imem request.
// Latency: 1 cycle minimum from imem_req to IF/ID load; first id_valid 2 cycles after reset release.
// Backpressure: id_stall parks one instruction in a skid entry and pauses requests; pc_stall holds the PC.
// Ports: clk/Reset, pc_q/pc_d from the PC register, pc_stall to it, flush redirect,
//        imem_req/imem_addr/imem_ack/imem_rdata memory side, id_stall in, id_valid/id_instr/id_pc/id_pc4 out.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,  // must equal FETCH_ADDR_W (payload struct width)
  parameter int DATA_W = FETCH_DATA_W   // must equal FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic [ADDR_W-1:0] pc_d,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              imem_req_q, imem_req_d;
  logic              id_valid_q, id_valid_d;
  logic [DATA_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;

  logic   accept;
  logic   id_load;
  if_id_t id_load_dat, fetch_dat, skid_dat;
  logic   skid_load, skid_unload, skid_clear, skid_vld;

  assign accept          = ~id_valid_q | ~id_stall;
  assign fetch_dat.instr = imem_rdata;
  assign fetch_dat.pc    = req_addr_q;
  assign skid_clear      = flush;

  // Invariant outside DRAIN: pc_q equals req_addr_q, so pc_d is always the
  // address that follows the instruction currently being fetched.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    pc_stall    = 1'b1;
    id_load     = 1'b0;
    id_load_dat = fetch_dat;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (flush) begin
          pc_stall   = 1'b0;
          req_addr_d = pc_d;
        end else begin
          req_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (flush) begin
          pc_stall = 1'b0;
          // Without an ack the old request is still in flight: keep its
          // address and wait in DRAIN; the PC register holds the target.
          if (imem_ack) req_addr_d = pc_d;
          else          state_d    = DRAIN;
        end else if (imem_ack) begin
          pc_stall   = 1'b0;
          req_addr_d = pc_d;
          if (accept) begin
            id_load = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_stall   = 1'b0;
          req_addr_d = pc_d;
          state_d    = FETCH;
        end else if (!id_stall) begin
          skid_unload = 1'b1;
          id_load     = skid_vld;
          id_load_dat = skid_dat;
          state_d     = FETCH;
        end
      end
      DRAIN: begin
        if (flush) begin
          pc_stall = 1'b0;
          if (imem_ack) begin
            req_addr_d = pc_d;
            state_d    = FETCH;
          end
        end else if (imem_ack) begin
          req_addr_d = pc_q;  // PC has been holding the redirect target
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IF/ID register: a consumed entry drops out unless replaced; flush wins.
  always_comb begin
    id_valid_d = id_valid_q & id_stall;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (id_load) begin
      id_valid_d = 1'b1;
      id_instr_d = id_load_dat.instr;
      id_pc_d    = id_load_dat.pc;
      id_pc4_d   = id_load_dat.pc + ADDR_W'(INSTR_BYTES);
    end
  end

  assign imem_req_d = (state_d == FETCH) || (state_d == DRAIN);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      imem_req_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      imem_req_q <= imem_req_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (Reset),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .load_dat  (fetch_dat),
    .entry_dat (skid_dat),
    .valid     (skid_vld)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = req_addr_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage: directed cycle table, async reset, randomized run.
// Latency: n/a.
// Backpressure: bench drives id_stall and memory latency.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] pc_r;
  logic [31:0] pc_d;
  logic        pc_stall;
  logic        flush;
  logic [31:0] tgt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // The PC register lives in the environment: it loads pc_d unless stalled.
  assign pc_d = flush ? tgt : pc_r + 32'd4;

  fetch_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .pc_q       (pc_r),
    .pc_d       (pc_d),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        flush;
    logic [31:0] tgt;
    logic        id_stall;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        chk_addr;
    logic        e_stall;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic f, input logic [31:0] t, input logic s, input logic a,
                     input logic er, input logic [31:0] ea, input logic ca,
                     input logic es, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.flush = f; v.tgt = t; v.id_stall = s; v.ack = a;
    v.e_req = er; v.e_addr = ea; v.chk_addr = ca;
    v.e_stall = es; v.e_vld = ev; v.e_pc = ep;
    vq.push_back(v);
  endtask

  // Called at the negedge after inputs settled: advance the PC model across the next edge.
  logic [31:0] pc_next;

  task automatic edge_step();
    pc_next = pc_stall ? pc_r : pc_d;
    @(posedge clk);
    #1;
    pc_r = pc_next;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        pending;
    int          mem_wait;
    int          delivered;

    Reset = 1'b0; pc_r = 32'd0; flush = 1'b0; tgt = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; id_stall = 1'b0;

    //      flush tgt           stall ack | req addr          chk stall vld pc
    add(0, 32'h0,         0, 0,   0, 32'h0,         1, 1, 0, 32'h0);         // IDLE
    add(0, 32'h0,         0, 1,   1, 32'h0,         1, 0, 0, 32'h0);         // zero-wait
    add(0, 32'h0,         0, 1,   1, 32'h4,         1, 0, 1, 32'h0);
    add(0, 32'h0,         0, 0,   1, 32'h8,         1, 1, 1, 32'h4);         // slow mem
    add(0, 32'h0,         0, 0,   1, 32'h8,         1, 1, 0, 32'h0);
    add(0, 32'h0,         0, 1,   1, 32'h8,         1, 0, 0, 32'h0);
    add(0, 32'h0,         1, 1,   1, 32'hC,         1, 0, 1, 32'h8);         // ack into skid
    add(0, 32'h0,         1, 0,   0, 32'h0,         0, 1, 1, 32'h8);         // HOLD
    add(0, 32'h0,         1, 0,   0, 32'h0,         0, 1, 1, 32'h8);
    add(0, 32'h0,         1, 0,   0, 32'h0,         0, 1, 1, 32'h8);
    add(0, 32'h0,         0, 0,   0, 32'h0,         0, 1, 1, 32'h8);         // release
    add(0, 32'h0,         0, 0,   1, 32'h10,        1, 1, 1, 32'hC);         // skid entry next
    add(1, 32'h100,       0, 0,   1, 32'h10,        1, 0, 0, 32'h0);         // flush outstanding
    add(0, 32'h0,         0, 0,   1, 32'h10,        1, 1, 0, 32'h0);         // DRAIN
    add(0, 32'h0,         0, 1,   1, 32'h10,        1, 1, 0, 32'h0);         // stale ack
    add(0, 32'h0,         0, 1,   1, 32'h100,       1, 0, 0, 32'h0);
    add(1, 32'h200,       0, 1,   1, 32'h104,       1, 0, 1, 32'h100);       // flush with ack
    add(0, 32'h0,         0, 1,   1, 32'h200,       1, 0, 0, 32'h0);
    add(0, 32'h0,         1, 1,   1, 32'h204,       1, 0, 1, 32'h200);       // into HOLD
    add(1, 32'h300,       1, 0,   0, 32'h0,         0, 0, 1, 32'h200);       // flush in HOLD
    add(0, 32'h0,         0, 1,   1, 32'h300,       1, 0, 0, 32'h0);
    add(0, 32'h0,         0, 0,   1, 32'h304,       1, 1, 1, 32'h300);
    add(1, 32'hFFFF_FFFC, 0, 1,   1, 32'h304,       1, 0, 0, 32'h0);         // to top of memory
    add(0, 32'h0,         0, 1,   1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0);
    add(0, 32'h0,         0, 0,   1, 32'h0,         1, 1, 1, 32'hFFFF_FFFC); // wrap
    add(1, 32'h40,        0, 0,   1, 32'h0,         1, 0, 0, 32'h0);         // into DRAIN
    add(0, 32'h0,         0, 0,   1, 32'h0,         1, 1, 0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc4", id_pc4, 32'd0);
    @(posedge clk);
    #1;
    Reset = 1'b1;

    // Directed cycle table
    for (int i = 0; i < vq.size(); i++) begin
      flush      = vq[i].flush;
      tgt        = vq[i].tgt;
      id_stall   = vq[i].id_stall;
      imem_ack   = vq[i].ack;
      imem_rdata = mem_fn(imem_addr);
      @(negedge clk);
      chk($sformatf("row%0d_imem_req", i), 32'(imem_req), 32'(vq[i].e_req));
      if (vq[i].chk_addr) chk($sformatf("row%0d_imem_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("row%0d_pc_stall", i), 32'(pc_stall), 32'(vq[i].e_stall));
      chk($sformatf("row%0d_id_valid", i), 32'(id_valid), 32'(vq[i].e_vld));
      if (vq[i].e_vld) begin
        chk($sformatf("row%0d_id_pc", i), id_pc, vq[i].e_pc);
        chk($sformatf("row%0d_id_instr", i), id_instr, mem_fn(vq[i].e_pc));
        chk($sformatf("row%0d_id_pc4", i), id_pc4, vq[i].e_pc + 32'd4);
      end
      edge_step();
    end

    // Asynchronous reset in the middle of DRAIN
    flush = 1'b0; imem_ack = 1'b0; id_stall = 1'b0;
    chk("drain_req_before_reset", 32'(imem_req), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_imem_req", 32'(imem_req), 32'd0);
    chk("async_imem_addr", imem_addr, 32'd0);
    chk("async_pc_stall", 32'(pc_stall), 32'd1);
    chk("async_id_valid", 32'(id_valid), 32'd0);
    chk("async_id_instr", id_instr, 32'd0);
    chk("async_id_pc", id_pc, 32'd0);
    chk("async_id_pc4", id_pc4, 32'd0);

    // Randomized run against a program-order model: decode must see
    // start, start+4, ... and, after each flush, target, target+4, ...
    pc_r = 32'h0000_1000;
    exp_pc = 32'h0000_1000;
    pending = 1'b0;
    prev_addr = 32'd0;
    mem_wait = 0;
    delivered = 0;
    @(posedge clk);
    #1;
    Reset = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      id_stall = ($urandom_range(0, 99) < 30);
      flush    = ($urandom_range(0, 99) < 4);
      tgt      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if (imem_req) begin
        imem_ack = (mem_wait == 0);
        if (imem_ack) mem_wait = $urandom_range(0, 3);
        else          mem_wait--;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
      end
      imem_rdata = mem_fn(imem_addr);
      @(negedge clk);
      if (pending && imem_req) chk("rnd_addr_stable", imem_addr, prev_addr);
      pending   = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (id_valid && !id_stall && !flush) begin
        chk("rnd_id_pc", id_pc, exp_pc);
        chk("rnd_id_instr", id_instr, mem_fn(exp_pc));
        chk("rnd_id_pc4", id_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (flush) exp_pc = tgt;
      edge_step();
    end
    n_chk++;
    if (delivered < 200) begin
      n_fail++;
      $display("FAIL rnd_progress: delivered %0d instructions, need at least 200", delivered);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
